// File: rtl/jk_excitation_enc.sv
// Encodes a target word into per-bit J/K excitation for a JK bank, shadows the bank and checks its Q feedback.
// Target to jk_valid: 2 cycles. jk_valid is held until jk_ready. tgt_ready is only high in IDLE. Optional JK_TOGGLE_PREF_EN: changing bits drive J=K=1.
module jk_excitation_enc #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [W-1:0]     tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [W-1:0]     j_out,
    output logic [W-1:0]     k_out,
    output logic             jk_valid,
    input  logic             jk_ready,
    input  logic [W-1:0]     q_fb,
    input  logic             clr_err,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_DRIVE = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     hold_q, hold_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     j_q, j_d;
    logic [W-1:0]     k_q, k_d;
    logic             jk_valid_q, jk_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [W-1:0] chg;
    logic [W-1:0] j_enc;
    logic [W-1:0] k_enc;

    assign chg = shadow_q ^ hold_q;

`ifdef JK_TOGGLE_PREF_EN
    // Don't-care resolved to 1 on changing bits: the bank toggles them.
    assign j_enc = chg;
    assign k_enc = chg;
`else
    assign j_enc = chg & hold_q;
    assign k_enc = chg & ~hold_q;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shadow_d   = shadow_q;
        j_d        = j_q;
        k_d        = k_q;
        jk_valid_d = jk_valid_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    hold_d  = tgt_data;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                j_d        = j_enc;
                k_d        = k_enc;
                jk_valid_d = 1'b1;
                state_d    = S_DRIVE;
            end
            S_DRIVE: begin
                if (jk_ready) begin
                    shadow_d   = hold_q;
                    jk_valid_d = 1'b0;
                    j_d        = '0;
                    k_d        = '0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                // The bank loaded the word on the same edge as the shadow, so q_fb is current here.
                if (q_fb != shadow_q) begin
                    err_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            shadow_q   <= '0;
            j_q        <= '0;
            k_q        <= '0;
            jk_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shadow_q   <= shadow_d;
            j_q        <= j_d;
            k_q        <= k_d;
            jk_valid_q <= jk_valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tgt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign jk_valid  = jk_valid_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_enc.sv
// Directed bench for jk_excitation_enc with a behavioural JK bank closing the q_fb loop.
module tb_jk_excitation_enc;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [3:0] tgt_data = 4'b0000;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic       jk_valid;
    logic       jk_ready = 1'b1;
    logic [3:0] q_fb;
    logic       clr_err = 1'b0;
    logic       err;
    logic [7:0] err_cnt;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [3:0] bank_q;
    logic       fault = 1'b0;
    logic [3:0] fault_val = 4'b0000;
    int         wr_cnt = 0;

    always #5 Clk = ~Clk;

    jk_excitation_enc #(.W(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .tgt_data(tgt_data), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .j_out(j_out), .k_out(k_out), .jk_valid(jk_valid), .jk_ready(jk_ready),
        .q_fb(q_fb), .clr_err(clr_err), .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    // JK bank: Qn = J&~Q | ~K&Q, resets with the encoder.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) bank_q <= 4'b0000;
        else if (jk_valid && jk_ready) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end

    always @(posedge Clk) begin
        if (!Rst && jk_valid && jk_ready) wr_cnt <= wr_cnt + 1;
    end

    assign q_fb = fault ? fault_val : bank_q;

    // One full write with jk_ready held high; returns what was seen in DRIVE and err once back in IDLE.
    task automatic write_tgt(input logic [3:0] t, output logic [3:0] jo, output logic [3:0] ko,
                             output logic vo, output logic eo);
        @(negedge Clk); tgt_data = t; tgt_valid = 1'b1; jk_ready = 1'b1;
        @(negedge Clk); tgt_valid = 1'b0;
        @(negedge Clk); jo = j_out; ko = k_out; vo = jk_valid;
        @(negedge Clk);
        @(negedge Clk); eo = err;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        checks++; if (jk_valid !== 1'b0) begin failures++; $display("FAIL reset_jk_valid: got %b want 0", jk_valid); end
        checks++; if ({j_out, k_out} !== 8'h00) begin failures++; $display("FAIL reset_jk: got j=%b k=%b want 0000/0000", j_out, k_out); end
        checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL reset_tgt_ready: got %b want 1", tgt_ready); end
        checks++; if ({err, err_cnt, busy} !== 10'd0) begin failures++; $display("FAIL reset_err: got err=%b cnt=%0d busy=%b want 0/0/0", err, err_cnt, busy); end
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if ({tgt_ready, busy} !== 2'b10) begin failures++; $display("FAIL reset_idle: got ready=%b busy=%b want 1/0", tgt_ready, busy); end
    endtask

    task automatic test_set();
        @(negedge Clk); tgt_data = 4'b1010; tgt_valid = 1'b1; jk_ready = 1'b1;
        @(negedge Clk); tgt_valid = 1'b0;
        checks++; if ({jk_valid, tgt_ready, busy} !== 3'b001) begin failures++; $display("FAIL set_enc_cycle: got valid=%b ready=%b busy=%b want 0/0/1", jk_valid, tgt_ready, busy); end
        @(negedge Clk);
        checks++; if (jk_valid !== 1'b1) begin failures++; $display("FAIL set_latency: got jk_valid=%b want 1", jk_valid); end
        checks++; if ({j_out, k_out} !== 8'b1010_0000) begin failures++; $display("FAIL set_jk: got j=%b k=%b want 1010/0000", j_out, k_out); end
        @(negedge Clk);
        checks++; if ({jk_valid, j_out, k_out} !== 9'd0) begin failures++; $display("FAIL set_check_cycle: got valid=%b j=%b k=%b want 0", jk_valid, j_out, k_out); end
        @(negedge Clk);
        checks++; if ({err, busy, bank_q} !== 6'b00_1010) begin failures++; $display("FAIL set_done: got err=%b busy=%b bank=%b want 0/0/1010", err, busy, bank_q); end
    endtask

    task automatic test_mixed();
        logic [3:0] jo, ko; logic vo, eo;
        logic [3:0] j_exp, k_exp;
`ifdef JK_TOGGLE_PREF_EN
        j_exp = 4'b1100; k_exp = 4'b1100;
`else
        j_exp = 4'b0100; k_exp = 4'b1000;
`endif
        write_tgt(4'b0110, jo, ko, vo, eo);
        checks++; if ({vo, jo, ko} !== {1'b1, j_exp, k_exp}) begin failures++; $display("FAIL mixed_jk: got v=%b j=%b k=%b want 1/%b/%b", vo, jo, ko, j_exp, k_exp); end
        checks++; if ({eo, bank_q} !== 5'b0_0110) begin failures++; $display("FAIL mixed_state: got err=%b bank=%b want 0/0110", eo, bank_q); end
        write_tgt(4'b0110, jo, ko, vo, eo);
        checks++; if ({vo, jo, ko} !== 9'b1_0000_0000) begin failures++; $display("FAIL mixed_shadow: got v=%b j=%b k=%b want 1/0000/0000", vo, jo, ko); end
    endtask

    task automatic test_backpressure();
        logic [3:0] j_exp, k_exp;
        int wc0;
`ifdef JK_TOGGLE_PREF_EN
        j_exp = 4'b1111; k_exp = 4'b1111;
`else
        j_exp = 4'b1001; k_exp = 4'b0110;
`endif
        @(negedge Clk); tgt_data = 4'b1001; tgt_valid = 1'b1; jk_ready = 1'b0;
        @(negedge Clk); tgt_valid = 1'b0;
        @(negedge Clk);
        wc0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({jk_valid, j_out, k_out, tgt_ready} !== {1'b1, j_exp, k_exp, 1'b0}) begin
                failures++; $display("FAIL bp_hold[%0d]: got v=%b j=%b k=%b ready=%b want 1/%b/%b/0", i, jk_valid, j_out, k_out, tgt_ready, j_exp, k_exp);
            end
            tgt_valid = (i == 2);
            tgt_data  = 4'b0000;
            @(negedge Clk);
        end
        tgt_valid = 1'b0; jk_ready = 1'b1;
        @(negedge Clk);
        checks++; if (jk_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b want 0", jk_valid); end
        checks++; if (wr_cnt - wc0 !== 1 || bank_q !== 4'b1001) begin failures++; $display("FAIL bp_one_write: got writes=%0d bank=%b want 1/1001", wr_cnt - wc0, bank_q); end
        @(negedge Clk);
        @(negedge Clk);
        checks++; if ({busy, err} !== 2'b00) begin failures++; $display("FAIL bp_not_queued: got busy=%b err=%b want 0/0", busy, err); end
    endtask

    task automatic test_hold_write();
        logic [3:0] jo, ko; logic vo, eo;
        write_tgt(4'b1001, jo, ko, vo, eo);
        checks++; if ({vo, jo, ko, eo} !== 10'b1_0000_0000_0) begin failures++; $display("FAIL hold_write: got v=%b j=%b k=%b err=%b want 1/0000/0000/0", vo, jo, ko, eo); end
    endtask

    task automatic test_mismatch();
        logic [3:0] jo, ko; logic vo, eo;
        fault = 1'b1; fault_val = 4'b0000;
        write_tgt(4'b0110, jo, ko, vo, eo);
        checks++; if ({eo, err_cnt} !== {1'b1, 8'd1}) begin failures++; $display("FAIL mismatch_first: got err=%b cnt=%0d want 1/1", eo, err_cnt); end
        for (int i = 0; i < 300; i++) write_tgt(4'b0110, jo, ko, vo, eo);
        checks++; if ({err, err_cnt} !== {1'b1, 8'd255}) begin failures++; $display("FAIL mismatch_saturate: got err=%b cnt=%0d want 1/255", err, err_cnt); end
        @(negedge Clk); tgt_data = 4'b0110; tgt_valid = 1'b1;
        @(negedge Clk); tgt_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk); clr_err = 1'b1;
        @(negedge Clk); clr_err = 1'b0;
        checks++; if ({err, err_cnt, busy} !== 10'd0) begin failures++; $display("FAIL mismatch_clr_priority: got err=%b cnt=%0d busy=%b want 0/0/0", err, err_cnt, busy); end
        fault = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] jo, ko; logic vo, eo;
        @(negedge Clk); tgt_data = 4'b0011; tgt_valid = 1'b1; jk_ready = 1'b0;
        @(negedge Clk); tgt_valid = 1'b0;
        @(negedge Clk);
        checks++; if (jk_valid !== 1'b1) begin failures++; $display("FAIL areset_in_drive: got jk_valid=%b want 1", jk_valid); end
        #2 Rst = 1'b1;
        #1;
        checks++; if ({jk_valid, j_out, k_out} !== 9'd0) begin failures++; $display("FAIL areset_outputs: got v=%b j=%b k=%b want 0", jk_valid, j_out, k_out); end
        checks++; if ({tgt_ready, busy} !== 2'b10) begin failures++; $display("FAIL areset_ready: got ready=%b busy=%b want 1/0", tgt_ready, busy); end
        @(negedge Clk); Rst = 1'b0; jk_ready = 1'b1;
        write_tgt(4'b0000, jo, ko, vo, eo);
        checks++; if ({vo, jo, ko, eo} !== 10'b1_0000_0000_0) begin failures++; $display("FAIL areset_shadow_zero: got v=%b j=%b k=%b err=%b want 1/0000/0000/0", vo, jo, ko, eo); end
        write_tgt(4'b0101, jo, ko, vo, eo);
`ifdef JK_TOGGLE_PREF_EN
        checks++; if ({jo, ko} !== 8'b0101_0101) begin failures++; $display("FAIL areset_next_write: got j=%b k=%b want 0101/0101", jo, ko); end
`else
        checks++; if ({jo, ko} !== 8'b0101_0000) begin failures++; $display("FAIL areset_next_write: got j=%b k=%b want 0101/0000", jo, ko); end
`endif
    endtask

    initial begin
        test_reset();
        test_set();
        test_mixed();
        test_backpressure();
        test_hold_write();
        test_mismatch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
